crank_wheel_gen: RTL and testbench
==================================

# crank_wheel_gen

Synthesizable, parametrised crank/cam trigger-wheel generator: produces a missing-tooth VR-style crank signal and a two-revolution cam signal. Tooth count, gap, pitch resolution, speed ramp and cam window are configurable. It drives the `hwag` capture input in simulation and in on-board self-test builds.

## Interface
- `PRESC_W`, 8: width of tick prescaler period.
- `TOOTH_W`, 8: width of tooth index.
- `TICK_W`, 8: width of intra-tooth tick counter; must hold TICKS*(1+GAP)-1.
- `TEETH`, 58: present teeth per revolution, indices 0..TEETH-1.
- `GAP`, 2: missing teeth after tooth TEETH-1.
- `TICKS`, 64: ticks per tooth pitch; even, ≥4.
- `CAM_TOGGLE_TOOTH`, 30: tooth whose entry toggles the cam phase.
- `PERIOD_RST`, 128: reset value of `period`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-low reset.
- `ena` in 1: advance enable; low = all counters and outputs hold.
- `load` in 1: restart at `start_tooth` with `period_init`.
- `period_init` in PRESC_W: prescaler period loaded by `load`.
- `start_tooth` in TOOTH_W: tooth loaded by `load`.
- `ramp` in 2: 00 hold, 01 accelerate, 10 decelerate, 11 hold.
- `period_min`, `period_max` in PRESC_W: ramp saturation limits.
- `cam_rise`, `cam_fall` in TOOTH_W: cam edge teeth.
- `vr` out 1: crank tooth signal.
- `cam` out 1: cam signal.
- `tooth` out TOOTH_W: current tooth index.
- `rev` out 1: one-clk pulse on wrap to tooth 0.
- `period` out PRESC_W: current prescaler period.

## Operation
- Reset (`rst`=0): scnt=0, tckc=0, `tooth`=0, `vr`=0, `rev`=0, `cam`=1, cam_phase=0, `period`=PERIOD_RST.
- Priority: reset > `load` > `ena`. `load` acts even with `ena`=0. It sets scnt=tckc=0, `vr`=0, `rev`=0, `cam`=1, cam_phase=0, `period`=`period_init`, and `tooth`=`start_tooth`; a `start_tooth` value ≥TEETH loads 0.
- Prescaler:
  - scnt counts 0..`period`; a tick fires when scnt==`period`, then scnt returns to 0.
  - `period`=0 ticks every clk.
- Tooth frame:
  - top = TICKS-1, or TICKS*(1+GAP)-1 when `tooth`==TEETH-1. top is combinational from `tooth`.
  - On a tick with tckc==top-TICKS/2: `vr`<=1.
  - On a tick with tckc==top: tckc<=0 and `vr`<=0. `tooth` advances, wrapping TEETH-1→0 with `rev`<=1.
  - Otherwise tckc increments on each tick.
- Resulting waveform: `vr` is high for TICKS/2 ticks at the end of every tooth. Low time is TICKS/2 ticks on normal teeth and TICKS*(1+GAP)-TICKS/2 ticks on the gap tooth.
- Ramp, applied at each tooth boundary:
  - Accelerate: `period`<=max(`period`-1, `period_min`).
  - Decelerate: `period`<=min(`period`+1, `period_max`).
  - Unsigned arithmetic; saturates at the limit and never wraps.
  - If `period` is already outside the limits, the ramp step clamps it to the violated limit.
- Cam, evaluated on entry to the new tooth value:
  - Entry to CAM_TOGGLE_TOOTH toggles cam_phase.
  - While cam_phase=1: entry to `cam_fall` drives `cam`<=0, and entry to `cam_rise` drives `cam`<=1. If `cam_rise`==`cam_fall`, rise wins.

## Timing
- All outputs are registered.
- `tooth`, `rev`, the `vr` fall, the `period` update and cam edges all change on the same clk edge, the one following the last tick of a tooth.
- `rev` is high for exactly one clk. It stays high across an `ena`=0 hold and is cleared on the next enabled clk.
- A new `period` value governs the very next prescaler count.
- Revolution length = (TEETH+GAP)*TICKS*(`period`+1) clks at constant period.
- Reset or `load` mid-tooth: takes effect on that edge. No partial `vr` pulse completes.

## Configuration
- `CRANK_WHEEL_GEN_CAM_EN` defined: cam_phase and `cam` logic is present as specified.
- Macro undefined:
  - `cam` is driven constant 0.
  - No cam registers are built.
  - `cam_rise`, `cam_fall` and CAM_TOGGLE_TOOTH are ignored.
  - Crank behaviour is unchanged.

## Structure
- Package `crank_wheel_pkg` holds:
  - The ramp-mode enum RAMP_HOLD, RAMP_ACCEL, RAMP_DECEL.
  - Default parameter constants.
  - A function computing top from the tooth index.
- Sub-module `crank_tick_presc` contains the scnt counter and tick strobe, with inputs `period`, `ena`, `load`, `rst` and output tick.

## Test plan
- Defaults, `period_init`=0, `ramp`=00, `load` pulse with `start_tooth`=0:
  - `vr` low 32 / high 32 clk per normal tooth.
  - Gap tooth: `vr` low 160 / high 32 clk.
  - `rev` pulses every 3840 clk; `tooth` sequence 0..57.
- `period_init`=3, `period_min`=1, `ramp`=01 → `period` reads 3,2,1,1 after successive tooth boundaries. Then `ramp`=10 with `period_max`=2 → `period` 2,2.
- Cam with `cam_rise`=4, `cam_fall`=54, `load` at tooth 0:
  - `cam` falls at entry to tooth 54 only in revolutions following an odd number of tooth-30 entries.
  - `cam` rises at the next entry to tooth 4.
  - Pattern repeats every 2 revolutions.
- `ena`=0 for 100 clk mid-tooth → `tooth`, tckc, `vr` and `period` frozen; the waveform resumes with 100-clk stretch only.
- `rst`=0 for one clk mid-gap with `vr`=1 → next cycle `vr`=0, `tooth`=0, `cam`=1, `period`=128.
- `load` with `start_tooth`=45 while `ena`=0 → `tooth`=45 immediately. `start_tooth`=70 → `tooth`=0.

Source files
------------

// File: rtl/crank_wheel_pkg.sv
`default_nettype none
// crank_wheel_pkg -- ramp-mode enum, default configuration and tooth-frame helper (rev 1.0)
package crank_wheel_pkg;

  typedef enum logic [1:0] {
    RAMP_HOLD  = 2'b00,
    RAMP_ACCEL = 2'b01,
    RAMP_DECEL = 2'b10
  } ramp_e;

  localparam int          DEF_PRESC_W          = 8;
  localparam int          DEF_TOOTH_W          = 8;
  localparam int          DEF_TICK_W           = 8;
  localparam int unsigned DEF_TEETH            = 58;
  localparam int unsigned DEF_GAP              = 2;
  localparam int unsigned DEF_TICKS            = 64;
  localparam int unsigned DEF_CAM_TOGGLE_TOOTH = 30;
  localparam int unsigned DEF_PERIOD_RST       = 128;

  // Last tick index of a tooth; the final present tooth absorbs the missing-tooth gap.
  function automatic int unsigned tooth_top(input int unsigned tooth_idx,
                                            input int unsigned teeth,
                                            input int unsigned gap,
                                            input int unsigned ticks);
    if (tooth_idx == teeth - 1) begin
      return ticks * (1 + gap) - 1;
    end
    return ticks - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crank_tick_presc.sv
`default_nettype none
// crank_tick_presc -- prescaler: scnt counts 0..period, tick strobes on the terminal count (rev 1.0)
module crank_tick_presc
  import crank_wheel_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               load,
  input  logic [PRESC_W-1:0] period,
  output logic               tick
);

  logic [PRESC_W-1:0] scnt;
  logic               terminal;

  // >= rather than == keeps the counter safe if period ever drops below scnt.
  assign terminal = (scnt >= period);
  assign tick     = rst && !load && ena && terminal;

  always_ff @(posedge clk) begin
    if (!rst) begin
      scnt <= '0;
    end else if (load) begin
      scnt <= '0;
    end else if (ena) begin
      scnt <= terminal ? '0 : scnt + PRESC_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/crank_wheel_gen.sv
`default_nettype none
// crank_wheel_gen -- missing-tooth VR crank and two-revolution cam trigger-wheel generator (rev 1.0)
// Cam logic is built only when CRANK_WHEEL_GEN_CAM_EN is defined; otherwise cam is tied low.
module crank_wheel_gen
  import crank_wheel_pkg::*;
#(
  parameter int          PRESC_W          = DEF_PRESC_W,
  parameter int          TOOTH_W          = DEF_TOOTH_W,
  parameter int          TICK_W           = DEF_TICK_W,
  parameter int unsigned TEETH            = DEF_TEETH,
  parameter int unsigned GAP              = DEF_GAP,
  parameter int unsigned TICKS            = DEF_TICKS,
  parameter int unsigned CAM_TOGGLE_TOOTH = DEF_CAM_TOGGLE_TOOTH,
  parameter int unsigned PERIOD_RST       = DEF_PERIOD_RST
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               load,
  input  logic [PRESC_W-1:0] period_init,
  input  logic [TOOTH_W-1:0] start_tooth,
  input  logic [1:0]         ramp,
  input  logic [PRESC_W-1:0] period_min,
  input  logic [PRESC_W-1:0] period_max,
  input  logic [TOOTH_W-1:0] cam_rise,
  input  logic [TOOTH_W-1:0] cam_fall,
  output logic               vr,
  output logic               cam,
  output logic [TOOTH_W-1:0] tooth,
  output logic               rev,
  output logic [PRESC_W-1:0] period
);

  localparam logic [TOOTH_W-1:0] LAST_TOOTH = TOOTH_W'(TEETH - 1);
  localparam logic [TICK_W-1:0]  HALF       = TICK_W'(TICKS / 2);

  logic               tick;
  logic [TICK_W-1:0]  tckc;
  logic [TICK_W-1:0]  top;
  logic [TOOTH_W-1:0] tooth_nxt;
  logic               wrap;
  logic               boundary;
  logic [PRESC_W-1:0] period_step;

  crank_tick_presc #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .load   (load),
    .period (period),
    .tick   (tick)
  );

  assign top       = TICK_W'(tooth_top(32'(tooth), TEETH, GAP, TICKS));
  assign wrap      = (tooth == LAST_TOOTH);
  assign tooth_nxt = wrap ? '0 : tooth + TOOTH_W'(1);
  assign boundary  = tick && (tckc == top);

  // Ramp step saturates at the limits; an out-of-range period snaps to the violated limit.
  always_comb begin
    period_step = period;
    case (ramp)
      RAMP_ACCEL: begin
        period_step = (period > period_min) ? period - PRESC_W'(1) : period_min;
        if (period_step > period_max) begin
          period_step = period_max;
        end
      end
      RAMP_DECEL: begin
        period_step = (period < period_max) ? period + PRESC_W'(1) : period_max;
        if (period_step < period_min) begin
          period_step = period_min;
        end
      end
      default: period_step = period;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tckc   <= '0;
      tooth  <= '0;
      vr     <= 1'b0;
      rev    <= 1'b0;
      period <= PRESC_W'(PERIOD_RST);
    end else if (load) begin
      tckc   <= '0;
      vr     <= 1'b0;
      rev    <= 1'b0;
      period <= period_init;
      tooth  <= (32'(start_tooth) >= TEETH) ? '0 : start_tooth;
    end else if (ena) begin
      rev <= 1'b0;
      if (boundary) begin
        tckc   <= '0;
        vr     <= 1'b0;
        tooth  <= tooth_nxt;
        rev    <= wrap;
        period <= period_step;
      end else if (tick) begin
        tckc <= tckc + TICK_W'(1);
        if (tckc == top - HALF) begin
          vr <= 1'b1;
        end
      end
    end
  end

`ifdef CRANK_WHEEL_GEN_CAM_EN
  localparam logic [TOOTH_W-1:0] CAM_TOGGLE = TOOTH_W'(CAM_TOGGLE_TOOTH);

  logic cam_phase;

  // Edges are qualified by the phase held before this entry; rise wins on a tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cam_phase <= 1'b0;
      cam       <= 1'b1;
    end else if (load) begin
      cam_phase <= 1'b0;
      cam       <= 1'b1;
    end else if (ena && boundary) begin
      if (tooth_nxt == CAM_TOGGLE) begin
        cam_phase <= ~cam_phase;
      end
      if (cam_phase) begin
        if (tooth_nxt == cam_rise) begin
          cam <= 1'b1;
        end else if (tooth_nxt == cam_fall) begin
          cam <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_cam_cfg;

  assign unused_cam_cfg = ^{cam_rise, cam_fall, TOOTH_W'(CAM_TOGGLE_TOOTH)};
  assign cam            = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crank_wheel_gen.sv
`default_nettype none
// tb_crank_wheel_gen -- randomized bench against a tick-count reference model of the trigger wheel (rev 1.0)
module tb_crank_wheel_gen;

  localparam int TEETH      = 58;
  localparam int GAP        = 2;
  localparam int TICKS      = 64;
  localparam int CAM_T      = 30;
  localparam int PERIOD_RST = 128;
  localparam int REV_CLKS   = (TEETH + GAP) * TICKS;
`ifdef CRANK_WHEEL_GEN_CAM_EN
  localparam bit CAM_EN = 1'b1;
`else
  localparam bit CAM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic       load = 1'b0;
  logic [7:0] period_init = 8'd0;
  logic [7:0] start_tooth = 8'd0;
  logic [1:0] ramp = 2'b00;
  logic [7:0] period_min = 8'd0;
  logic [7:0] period_max = 8'd255;
  logic [7:0] cam_rise = 8'd4;
  logic [7:0] cam_fall = 8'd54;
  logic       vr;
  logic       cam;
  logic [7:0] tooth;
  logic       rev;
  logic [7:0] period;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference state: position on the wheel as ticks into the tooth and clks into the tick.
  int m_tooth, m_tick, m_sub, m_period;
  bit m_rev, m_cam, m_phase;

  crank_wheel_gen dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .load        (load),
    .period_init (period_init),
    .start_tooth (start_tooth),
    .ramp        (ramp),
    .period_min  (period_min),
    .period_max  (period_max),
    .cam_rise    (cam_rise),
    .cam_fall    (cam_fall),
    .vr          (vr),
    .cam         (cam),
    .tooth       (tooth),
    .rev         (rev),
    .period      (period)
  );

  always #5 clk = ~clk;

  function automatic int tooth_len(input int t);
    return (t == TEETH - 1) ? TICKS * (1 + GAP) : TICKS;
  endfunction

  // vr is high during the last TICKS/2 ticks of every tooth.
  function automatic bit m_vr();
    return m_tick >= tooth_len(m_tooth) - TICKS / 2;
  endfunction

  function automatic logic [7:0] pick_cam_tooth();
    int r;
    r = $urandom_range(0, TEETH - 1);
    while (r == CAM_T) r = $urandom_range(0, TEETH - 1);
    return 8'(r);
  endfunction

  task automatic model_step();
    int nt;
    bit old_phase;
    if (rst === 1'b0) begin
      m_tooth = 0; m_tick = 0; m_sub = 0; m_rev = 0;
      m_cam = CAM_EN; m_phase = 0; m_period = PERIOD_RST;
    end else if (load) begin
      m_tooth = (int'(start_tooth) >= TEETH) ? 0 : int'(start_tooth);
      m_tick = 0; m_sub = 0; m_rev = 0;
      m_cam = CAM_EN; m_phase = 0; m_period = int'(period_init);
    end else if (ena) begin
      m_rev = 0;
      m_sub++;
      if (m_sub > m_period) begin
        m_sub = 0;
        m_tick++;
        if (m_tick == tooth_len(m_tooth)) begin
          m_tick = 0;
          nt = (m_tooth + 1) % TEETH;
          if (nt == 0) m_rev = 1;
          m_tooth = nt;
          if (ramp == 2'b01)
            m_period = (m_period - 1 > int'(period_min)) ? m_period - 1 : int'(period_min);
          else if (ramp == 2'b10)
            m_period = (m_period + 1 < int'(period_max)) ? m_period + 1 : int'(period_max);
          if (CAM_EN) begin
            old_phase = m_phase;
            if (nt == CAM_T) m_phase = !m_phase;
            if (old_phase) begin
              if (nt == int'(cam_rise)) m_cam = 1;
              else if (nt == int'(cam_fall)) m_cam = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0; ena = 1'b0; load = 1'b0;
    step(); step();
    checks++; if (vr !== 1'b0) begin errors++; $display("FAIL reset_vr got %b want 0", vr); end
    checks++; if (rev !== 1'b0) begin errors++; $display("FAIL reset_rev got %b want 0", rev); end
    checks++; if (tooth !== 8'd0) begin errors++; $display("FAIL reset_tooth got %0d want 0", tooth); end
    checks++; if (period !== 8'(PERIOD_RST)) begin errors++; $display("FAIL reset_period got %0d want %0d", period, PERIOD_RST); end
    checks++; if (cam !== CAM_EN) begin errors++; $display("FAIL reset_cam got %b want %b", cam, CAM_EN); end
    rst = 1'b1;
  endtask

  task automatic test_waveform();
    int rev_at[$];
    int gap_lo = 0, gap_hi = 0, t5_lo = 0, t5_hi = 0;
    period_init = 8'd0; start_tooth = 8'd0; ramp = 2'b00;
    load = 1'b1; step(); load = 1'b0; ena = 1'b1;
    for (int i = 0; i < 2 * REV_CLKS + 64; i++) begin
      step();
      checks++;
      if ({vr, cam, rev, tooth, period} !== {m_vr(), m_cam, m_rev, 8'(m_tooth), 8'(m_period)}) begin
        errors++;
        if (errors < 20) $display("FAIL wave cyc=%0d got vr=%b cam=%b rev=%b tooth=%0d period=%0d want vr=%b cam=%b rev=%b tooth=%0d period=%0d",
                                  cyc, vr, cam, rev, tooth, period, m_vr(), m_cam, m_rev, m_tooth, m_period);
      end
      if (rev === 1'b1) rev_at.push_back(i);
      if (i < REV_CLKS && tooth == 8'(TEETH - 1)) begin if (vr) gap_hi++; else gap_lo++; end
      if (i < REV_CLKS && tooth == 8'd5) begin if (vr) t5_hi++; else t5_lo++; end
    end
    checks++; if (gap_lo != 160) begin errors++; $display("FAIL gap_low got %0d want 160", gap_lo); end
    checks++; if (gap_hi != 32) begin errors++; $display("FAIL gap_high got %0d want 32", gap_hi); end
    checks++; if (t5_lo != 32) begin errors++; $display("FAIL tooth_low got %0d want 32", t5_lo); end
    checks++; if (t5_hi != 32) begin errors++; $display("FAIL tooth_high got %0d want 32", t5_hi); end
    checks++;
    if (rev_at.size() != 2) begin
      errors++; $display("FAIL rev_count got %0d want 2", rev_at.size());
    end else begin
      checks++; if (rev_at[0] != REV_CLKS - 1) begin errors++; $display("FAIL first_rev got %0d want %0d", rev_at[0], REV_CLKS - 1); end
      checks++; if (rev_at[1] - rev_at[0] != REV_CLKS) begin errors++; $display("FAIL rev_interval got %0d want %0d", rev_at[1] - rev_at[0], REV_CLKS); end
    end
  endtask

  task automatic test_ramp();
    int exp_p[5] = '{2, 1, 1, 2, 2};
    logic [7:0] prev;
    int budget;
    period_init = 8'd3; period_min = 8'd1; period_max = 8'd255; ramp = 2'b01; start_tooth = 8'd0;
    load = 1'b1; step(); load = 1'b0; ena = 1'b1;
    checks++; if (period !== 8'd3) begin errors++; $display("FAIL ramp_init got %0d want 3", period); end
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin ramp = 2'b10; period_max = 8'd2; end
      prev = tooth;
      budget = 0;
      while (tooth == prev && budget < 2000) begin
        step();
        budget++;
        checks++;
        if ({vr, rev, tooth, period} !== {m_vr(), m_rev, 8'(m_tooth), 8'(m_period)}) begin
          errors++;
          if (errors < 20) $display("FAIL ramp_track cyc=%0d got tooth=%0d period=%0d want tooth=%0d period=%0d",
                                    cyc, tooth, period, m_tooth, m_period);
        end
      end
      checks++;
      if (budget >= 2000) begin errors++; $display("FAIL ramp_timeout got %0d clks want boundary", budget); end
      checks++; if (period !== 8'(exp_p[k])) begin errors++; $display("FAIL ramp_step%0d got %0d want %0d", k, period, exp_p[k]); end
    end
  endtask

  task automatic test_cam();
    int falls = 0, rises = 0;
    logic prev_cam;
    cam_rise = 8'd4; cam_fall = 8'd54; period_init = 8'd0; ramp = 2'b00; start_tooth = 8'd0;
    load = 1'b1; step(); load = 1'b0; ena = 1'b1;
    prev_cam = cam;
    for (int i = 0; i < 4 * REV_CLKS; i++) begin
      step();
      checks++;
      if ({vr, cam, rev, tooth, period} !== {m_vr(), m_cam, m_rev, 8'(m_tooth), 8'(m_period)}) begin
        errors++;
        if (errors < 20) $display("FAIL cam_track cyc=%0d got cam=%b tooth=%0d want cam=%b tooth=%0d", cyc, cam, tooth, m_cam, m_tooth);
      end
      if (prev_cam === 1'b1 && cam === 1'b0) begin
        falls++;
        checks++; if (tooth !== 8'd54) begin errors++; $display("FAIL cam_fall_tooth got %0d want 54", tooth); end
      end
      if (prev_cam === 1'b0 && cam === 1'b1) begin
        rises++;
        checks++; if (tooth !== 8'd4) begin errors++; $display("FAIL cam_rise_tooth got %0d want 4", tooth); end
      end
      prev_cam = cam;
    end
    checks++; if (falls != (CAM_EN ? 2 : 0)) begin errors++; $display("FAIL cam_falls got %0d want %0d", falls, CAM_EN ? 2 : 0); end
    checks++; if (rises != (CAM_EN ? 2 : 0)) begin errors++; $display("FAIL cam_rises got %0d want %0d", rises, CAM_EN ? 2 : 0); end
  endtask

  task automatic test_ena_hold();
    logic [7:0] t0, s_tooth, s_period;
    logic s_vr;
    int entry, budget;
    ramp = 2'b00; ena = 1'b1;
    t0 = tooth; budget = 0;
    while (tooth == t0 && budget < 300) begin step(); budget++; end
    checks++; if (budget >= 300) begin errors++; $display("FAIL hold_sync got %0d clks want boundary", budget); end
    t0 = tooth; entry = cyc;
    for (int i = 0; i < 40; i++) step();
    s_tooth = tooth; s_vr = vr; s_period = period;
    ena = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if ({tooth, vr, period} !== {s_tooth, s_vr, s_period} || {tooth, vr} !== {8'(m_tooth), m_vr()}) begin
        errors++;
        if (errors < 20) $display("FAIL hold_frozen cyc=%0d got tooth=%0d vr=%b period=%0d want tooth=%0d vr=%b period=%0d",
                                  cyc, tooth, vr, period, s_tooth, s_vr, s_period);
      end
    end
    ena = 1'b1; budget = 0;
    while (tooth == t0 && budget < 600) begin step(); budget++; end
    checks++;
    if (cyc - entry != tooth_len(int'(t0)) + 100) begin
      errors++; $display("FAIL hold_stretch got %0d clks want %0d", cyc - entry, tooth_len(int'(t0)) + 100);
    end
    budget = 0;
    while (rev !== 1'b1 && budget < 2 * REV_CLKS) begin step(); budget++; end
    checks++; if (rev !== 1'b1) begin errors++; $display("FAIL rev_wait got %b want 1", rev); end
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (rev !== 1'b1) begin errors++; $display("FAIL rev_hold got %b want 1", rev); end
    end
    ena = 1'b1; step();
    checks++; if (rev !== 1'b0) begin errors++; $display("FAIL rev_clear got %b want 0", rev); end
  endtask

  task automatic test_reset_mid_gap();
    int budget = 0;
    ena = 1'b1;
    while (!(tooth == 8'(TEETH - 1) && vr === 1'b1) && budget < 2 * REV_CLKS) begin step(); budget++; end
    checks++; if (vr !== 1'b1 || tooth !== 8'(TEETH - 1)) begin errors++; $display("FAIL gap_wait got tooth=%0d vr=%b want tooth=%0d vr=1", tooth, vr, TEETH - 1); end
    rst = 1'b0; step(); rst = 1'b1;
    checks++; if (vr !== 1'b0) begin errors++; $display("FAIL rstgap_vr got %b want 0", vr); end
    checks++; if (tooth !== 8'd0) begin errors++; $display("FAIL rstgap_tooth got %0d want 0", tooth); end
    checks++; if (cam !== CAM_EN) begin errors++; $display("FAIL rstgap_cam got %b want %b", cam, CAM_EN); end
    checks++; if (period !== 8'(PERIOD_RST)) begin errors++; $display("FAIL rstgap_period got %0d want %0d", period, PERIOD_RST); end
  endtask

  task automatic test_load_disabled();
    ena = 1'b0; period_init = 8'd2; start_tooth = 8'd45;
    load = 1'b1; step(); load = 1'b0;
    checks++; if (tooth !== 8'd45) begin errors++; $display("FAIL load45 got %0d want 45", tooth); end
    checks++; if (period !== 8'd2) begin errors++; $display("FAIL load_period got %0d want 2", period); end
    for (int i = 0; i < 10; i++) step();
    checks++; if (tooth !== 8'd45) begin errors++; $display("FAIL load_hold got %0d want 45", tooth); end
    start_tooth = 8'd70;
    load = 1'b1; step(); load = 1'b0;
    checks++; if (tooth !== 8'd0) begin errors++; $display("FAIL load70 got %0d want 0", tooth); end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 12; seg++) begin
      period_min  = 8'($urandom_range(0, 2));
      period_max  = period_min + 8'($urandom_range(0, 2));
      period_init = 8'($urandom_range(int'(period_min), int'(period_max)));
      start_tooth = (seg % 2 == 1) ? 8'($urandom_range(50, 70)) : 8'($urandom_range(0, TEETH - 1));
      cam_rise    = pick_cam_tooth();
      cam_fall    = pick_cam_tooth();
      ramp        = 2'($urandom_range(0, 3));
      ena         = 1'($urandom_range(0, 1));
      load = 1'b1; step(); load = 1'b0;
      for (int i = 0; i < 900; i++) begin
        ena = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 99) == 0) ramp = 2'($urandom_range(0, 3));
        step();
        checks++;
        if ({vr, cam, rev, tooth, period} !== {m_vr(), m_cam, m_rev, 8'(m_tooth), 8'(m_period)}) begin
          errors++;
          if (errors < 20) $display("FAIL rand seg=%0d cyc=%0d got vr=%b cam=%b rev=%b tooth=%0d period=%0d want vr=%b cam=%b rev=%b tooth=%0d period=%0d",
                                    seg, cyc, vr, cam, rev, tooth, period, m_vr(), m_cam, m_rev, m_tooth, m_period);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_waveform();
    test_ramp();
    test_cam();
    test_ena_hold();
    test_reset_mid_gap();
    test_load_disabled();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
